// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised asynchronous serial receiver.
//
// Receives one start bit, DATA_BITS data bits (LSB first), an optional parity
// bit and STOP_BITS stop bits. The rx pin passes through a two-flop
// synchroniser before use. Completed words go into a single-entry
// ready/valid output buffer. If that buffer is still full when a frame
// completes, the new word is dropped and overrun pulses for one cycle.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, one parity bit follows the data bits and the rx_perr port
//   is present. PARITY_ODD selects the parity sense: 0 = even, 1 = odd.
//
// Parameters
//   CLOCK_BIT  : clock cycles per bit (>= 4, fits in 16 bits)
//   DATA_BITS  : data bits per frame, 5..9
//   STOP_BITS  : stop bits per frame, 1 or 2
//   PARITY_ODD : parity sense, used only with UART_RX_PARITY_EN
//
// Ports
//   clock    : system clock
//   reset    : synchronous active-high reset
//   rx       : asynchronous serial input, idle high
//   rx_data  : received word, stable while rx_valid = 1
//   rx_valid : rx_data holds an unconsumed word
//   rx_ready : consumer accepts the word when high with rx_valid
//   rx_ferr  : framing error (a stop bit sampled 0) for the word in rx_data
//   rx_perr  : parity error for the word in rx_data (macro builds only)
//   overrun  : one-cycle pulse, a completed frame was dropped
//   busy     : receiver is in any state other than IDLE
module uart_rx_param #(
  parameter int CLOCK_BIT  = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_ferr,
`ifdef UART_RX_PARITY_EN
  output logic                 rx_perr,
`endif
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [15:0]      HALF_M1   = 16'(CLOCK_BIT / 2 - 1);
  localparam logic [15:0]      BIT_M1    = 16'(CLOCK_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  // Elaboration-time parameter legality checks.
  if (CLOCK_BIT < 4 || CLOCK_BIT > 65535) begin : g_bad_clock_bit
    $error("uart_rx_param: CLOCK_BIT out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS out of range");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_rx_param: PARITY_ODD must be 0 or 1");
  end

  logic                 r_sync1;
  logic                 r_sync2;
  logic [2:0]           r_state;
  logic [15:0]          r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;

  logic w_rxs;
  logic w_bit_tick;
  logic w_done;
  logic w_ferr;

  // Synchroniser: rx is asynchronous, so two flops before any use.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs      = r_sync2;
  assign w_bit_tick = (r_cnt == BIT_M1);

  // A frame completes on the first stop sample that reads 0. Otherwise it
  // completes on the last stop sample. Remaining stop bits after an error
  // are not sampled.
  assign w_done = (r_state == S_STOP) && w_bit_tick &&
                  (!w_rxs || (r_stop_idx == LAST_STOP));
  assign w_ferr = !w_rxs;

  assign busy = (r_state != S_IDLE);

  // Frame sequencing FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 16'd0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt      <= 16'd0;
          r_idx      <= '0;
          r_stop_idx <= 1'b0;
          if (!w_rxs) r_state <= S_START;
        end
        S_START: begin
          // Mid-start sample. A high line here is a glitch and is ignored.
          if (r_cnt == HALF_M1) begin
            r_cnt   <= 16'd0;
            r_state <= w_rxs ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            r_cnt <= 16'd0;
            if (r_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_tick) begin
            r_cnt   <= 16'd0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_tick) begin
            r_cnt <= 16'd0;
            if (!w_rxs) begin
              r_state <= S_WAIT_HIGH;
            end else if (r_stop_idx == LAST_STOP) begin
              r_state <= S_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_WAIT_HIGH: begin
          // Hold off until the line is released, so a break cannot
          // re-trigger START.
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data capture. Every bit position is rewritten each frame, so no reset
  // is needed here.
  always_ff @(posedge clock) begin
    if (r_state == S_DATA && w_bit_tick) r_shift[r_idx] <= w_rxs;
  end

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic w_perr;

  always_ff @(posedge clock) begin
    if (r_state == S_PARITY && w_bit_tick) r_par <= w_rxs;
  end

  assign w_perr = ((^r_shift) ^ r_par) != 1'(PARITY_ODD);
`endif

  // Output buffer. A completed frame loads the buffer if it is empty or
  // being drained in the same cycle. Otherwise the frame is dropped and
  // flagged with overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_perr  <= 1'b0;
`endif
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shift;
          rx_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
          rx_perr  <= w_perr;
`endif
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param -- directed bench for uart_rx_param.
// Instance u_dut8: CLOCK_BIT=16, DATA_BITS=8, STOP_BITS=1.
// Instance u_dut5: CLOCK_BIT=16, DATA_BITS=5, STOP_BITS=2.
module tb_uart_rx_param;

  localparam int CB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       rx8  = 1'b1;
  logic       rx5  = 1'b1;
  logic       rdy8 = 1'b1;
  logic       rdy5 = 1'b1;
  logic [7:0] d8;
  logic [4:0] d5;
  logic       v8, fe8, ov8, b8;
  logic       v5, fe5, ov5, b5;
`ifdef UART_RX_PARITY_EN
  logic       pe8, pe5;
`endif

  uart_rx_param #(.CLOCK_BIT(CB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut8 (
    .clock(clk), .reset(rst), .rx(rx8), .rx_data(d8), .rx_valid(v8),
    .rx_ready(rdy8), .rx_ferr(fe8),
`ifdef UART_RX_PARITY_EN
    .rx_perr(pe8),
`endif
    .overrun(ov8), .busy(b8));

  uart_rx_param #(.CLOCK_BIT(CB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) u_dut5 (
    .clock(clk), .reset(rst), .rx(rx5), .rx_data(d5), .rx_valid(v5),
    .rx_ready(rdy5), .rx_ferr(fe5),
`ifdef UART_RX_PARITY_EN
    .rx_perr(pe5),
`endif
    .overrun(ov5), .busy(b5));

  int checks   = 0;
  int failures = 0;

  // Event counters, sampled on the falling edge.
  int   rise8 = 0, hi8 = 0, ovc8 = 0, rise5 = 0, ovc5 = 0;
  logic v8_q = 1'b0, v5_q = 1'b0;

  always @(negedge clk) begin
    if (v8 && !v8_q) rise8 <= rise8 + 1;
    if (v8)          hi8   <= hi8 + 1;
    if (ov8)         ovc8  <= ovc8 + 1;
    if (v5 && !v5_q) rise5 <= rise5 + 1;
    if (ov5)         ovc5  <= ovc5 + 1;
    v8_q <= v8;
    v5_q <= v5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic epar(input logic [8:0] d, input int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < n; i++) p = p ^ d[i];
    return p;
  endfunction

  task automatic drive(input logic sel, input logic b);
    if (sel) rx5 = b;
    else     rx8 = b;
  endtask

  task automatic bit_wait();
    repeat (CB) @(posedge clk);
    #1;
  endtask

  // One frame: start, data LSB first, optional parity, stop bits taken from
  // stopv[0], stopv[1]. The line is left at idle_after once the frame ends.
  task automatic send(input logic sel, input logic [8:0] data, input int nbits,
                      input logic par, input int nstop, input logic [1:0] stopv,
                      input logic idle_after);
    drive(sel, 1'b0);
    bit_wait();
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      bit_wait();
    end
`ifdef UART_RX_PARITY_EN
    drive(sel, par);
    bit_wait();
`else
    if (par === 1'bz) drive(sel, 1'b1);
`endif
    for (int i = 0; i < nstop; i++) begin
      drive(sel, stopv[i]);
      bit_wait();
    end
    drive(sel, idle_after);
    repeat (4) @(posedge clk);
    #1;
  endtask

  int r0, h0, o0;

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",  32'(d8),  32'h0);
    chk("rst_valid", 32'(v8),  32'h0);
    chk("rst_ferr",  32'(fe8), 32'h0);
    chk("rst_ovr",   32'(ov8), 32'h0);
    chk("rst_busy",  32'(b8),  32'h0);
    chk("rst_data5", 32'(d5),  32'h0);
`ifdef UART_RX_PARITY_EN
    chk("rst_perr",  32'(pe8), 32'h0);
`endif
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Basic receive 0xA5
    r0 = rise8; h0 = hi8; o0 = ovc8;
    send(1'b0, 9'h0A5, 8, epar(9'h0A5, 8), 1, 2'b11, 1'b1);
    chk("basic_data",  32'(d8),     32'hA5);
    chk("basic_ferr",  32'(fe8),    32'h0);
    chk("basic_rise",  32'(rise8 - r0), 32'd1);
    chk("basic_width", 32'(hi8 - h0),   32'd1);
    chk("basic_ovr",   32'(ovc8 - o0),  32'd0);
    chk("basic_busy",  32'(b8),     32'h0);

    // Glitch rejection, then 0x3C
    r0 = rise8;
    rx8 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx8 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_busy",  32'(b8),  32'h0);
    chk("glitch_valid", 32'(v8),  32'h0);
    chk("glitch_rise",  32'(rise8 - r0), 32'd0);
    chk("glitch_data",  32'(d8),  32'hA5);
    send(1'b0, 9'h03C, 8, epar(9'h03C, 8), 1, 2'b11, 1'b1);
    chk("glitch_next_data", 32'(d8), 32'h3C);
    chk("glitch_next_rise", 32'(rise8 - r0), 32'd1);

    // Back-pressure and overrun
    rdy8 = 1'b0;
    r0 = rise8; o0 = ovc8;
    send(1'b0, 9'h011, 8, epar(9'h011, 8), 1, 2'b11, 1'b1);
    chk("bp_first_valid", 32'(v8), 32'h1);
    chk("bp_first_data",  32'(d8), 32'h11);
    send(1'b0, 9'h022, 8, epar(9'h022, 8), 1, 2'b11, 1'b1);
    chk("ovr_data",  32'(d8), 32'h11);
    chk("ovr_valid", 32'(v8), 32'h1);
    chk("ovr_pulse", 32'(ovc8 - o0), 32'd1);
    chk("ovr_rise",  32'(rise8 - r0), 32'd1);
    rdy8 = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(v8), 32'h0);
    chk("drain_data",  32'(d8), 32'h11);

    // Framing error followed by a held break
    r0 = rise8;
    send(1'b0, 9'h055, 8, epar(9'h055, 8), 1, 2'b00, 1'b0);
    chk("ferr_data", 32'(d8),  32'h55);
    chk("ferr_flag", 32'(fe8), 32'h1);
    chk("ferr_busy", 32'(b8),  32'h1);
    repeat (100) @(posedge clk);
    #1;
    chk("break_busy", 32'(b8), 32'h1);
    chk("break_rise", 32'(rise8 - r0), 32'd1);
    rx8 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("release_busy", 32'(b8), 32'h0);
    repeat (50) @(posedge clk);
    #1;
    chk("release_rise", 32'(rise8 - r0), 32'd1);

    // Mid-frame reset, then 0x81
    rx8 = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("mid_busy", 32'(b8), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy",  32'(b8),  32'h0);
    chk("mid_rst_valid", 32'(v8),  32'h0);
    chk("mid_rst_data",  32'(d8),  32'h0);
    chk("mid_rst_ferr",  32'(fe8), 32'h0);
    rx8 = 1'b1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(b8), 32'h0);
    send(1'b0, 9'h081, 8, epar(9'h081, 8), 1, 2'b11, 1'b1);
    chk("post_rst_data", 32'(d8),  32'h81);
    chk("post_rst_ferr", 32'(fe8), 32'h0);

    // 5 data bits, 2 stop bits
    r0 = rise5; o0 = ovc5;
    send(1'b1, 9'h01F, 5, epar(9'h01F, 5), 2, 2'b11, 1'b1);
    chk("w5_data", 32'(d5),  32'h1F);
    chk("w5_ferr", 32'(fe5), 32'h0);
    chk("w5_rise", 32'(rise5 - r0), 32'd1);
    send(1'b1, 9'h00A, 5, epar(9'h00A, 5), 2, 2'b01, 1'b1);
    chk("w5_err_data", 32'(d5),  32'h0A);
    chk("w5_err_ferr", 32'(fe5), 32'h1);
    chk("w5_err_rise", 32'(rise5 - r0), 32'd2);
    chk("w5_ovr",      32'(ovc5 - o0),  32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("w5_idle", 32'(b5), 32'h0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones
    send(1'b0, 9'h007, 8, 1'b1, 1, 2'b11, 1'b1);
    chk("par_ok_data", 32'(d8),  32'h07);
    chk("par_ok_perr", 32'(pe8), 32'h0);
    send(1'b0, 9'h007, 8, 1'b0, 1, 2'b11, 1'b1);
    chk("par_bad_perr", 32'(pe8), 32'h1);
    chk("par_bad_ferr", 32'(fe8), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
